tinyrv1_mem_responder: RTL and testbench

- Responder end of the TinyRV1 memory request/response interface; serves imemreq (fetch) or dmemreq (LW/SW) traffic issued by the processor pipeline.
- Word-addressed storage with val/rdy request and response channels, fixed configurable latency and an in-order response queue that absorbs backpressure.
- Used as the instruction or data memory in processor test harnesses. Instantiate once per port.
- Includes a backdoor load port so benches can preload programs and data.

---
 rtl/tinyrv1_mem_pkg.sv | 20 ++
 rtl/mem_resp_queue.sv | 57 +++++
 rtl/tinyrv1_mem_responder.sv | 119 +++++++++++
 tb/tb_tinyrv1_mem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tinyrv1_mem_pkg.sv
// Shared types and helpers for the TinyRV1 memory responder.
// Request type codes, response bundle and word indexing.
package tinyrv1_mem_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  typedef struct packed {
    logic        typ;
    logic [31:0] rdata;
  } mem_resp_t;

  function automatic logic [31:0] word_index(
    input logic [31:0] addr,
    input int unsigned words
  );
    return (addr >> 2) & (words - 1);
  endfunction

endpackage

// File: rtl/mem_resp_queue.sv
// In-order response FIFO of mem_resp_t.
// Head reads as zero while empty.
module mem_resp_queue
  import tinyrv1_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  mem_resp_t push_data,
  input  logic      pop,
  output mem_resp_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  mem_resp_t      slots [DEPTH];
  logic [PW-1:0]  wp;
  logic [PW-1:0]  rp;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : slots[rp];

  // Payload storage; contents are don't-care while not counted.
  always_ff @(posedge clk) begin
    if (do_push) slots[wp] <= push_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= ptr_inc(wp);
      if (do_pop)  rp <= ptr_inc(rp);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/tinyrv1_mem_responder.sv
// TinyRV1 memory responder: word array, latency pipe,
// credit counter and in-order response queue.
module tinyrv1_mem_responder
  import tinyrv1_mem_pkg::*;
#(
  parameter int WORDS   = 256,
  parameter int LATENCY = 1,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic        req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic        resp_type,
  output logic [31:0] resp_rdata,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int AW = $clog2(WORDS);
  localparam int CW = $clog2(QDEPTH + 1);

  logic [31:0]   mem [WORDS];
  logic [AW-1:0] idx;
  logic [AW-1:0] ld_idx;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          deliver;
  logic          push;
  logic          q_full;
  logic          q_empty;
  mem_resp_t     entry;
  mem_resp_t     push_data;
  mem_resp_t     q_head;

  assign idx     = AW'(word_index(req_addr, WORDS));
  assign ld_idx  = AW'(word_index(ld_addr, WORDS));
  assign req_rdy = (cnt < CW'(QDEPTH));
  assign accept  = req_val && req_rdy && rst;
  assign deliver = resp_val && resp_rdy;

  assign entry.typ   = req_type;
  assign entry.rdata = (req_type == MEMREQ_WRITE) ? '0 : mem[idx];

  // Array update; backdoor load is last so it wins a collision.
  always_ff @(posedge clk) begin
    if (accept && req_type == MEMREQ_WRITE) mem[idx] <= req_wdata;
    if (ld_en) mem[ld_idx] <= ld_data;
  end

  if (LATENCY == 1) begin : g_direct
    assign push      = accept;
    assign push_data = entry;
  end else begin : g_pipe
    logic [LATENCY-2:0] pv;
    mem_resp_t          pd [LATENCY-1];

    // Fixed-delay shift of accepted responses toward the queue.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pv <= '0;
        for (int i = 0; i < LATENCY - 1; i++) pd[i] <= '0;
      end else begin
        pv[0] <= accept;
        pd[0] <= entry;
        for (int i = 1; i < LATENCY - 1; i++) begin
          pv[i] <= pv[i-1];
          pd[i] <= pd[i-1];
        end
      end
    end

    assign push      = pv[LATENCY-2];
    assign push_data = pd[LATENCY-2];
  end

  mem_resp_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (deliver),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign resp_val   = !q_empty;
  assign resp_type  = q_head.typ;
  assign resp_rdata = q_head.rdata;

  // Credits: responses accepted but not yet delivered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (accept && !deliver) begin
      cnt <= cnt + 1'b1;
    end else if (deliver && !accept) begin
      cnt <= cnt - 1'b1;
    end
  end

  a_known_ctrl: assert property (
    @(posedge clk) disable iff (!rst)
    !$isunknown({req_val, resp_rdy})
  );

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
    !(push && q_full)
  );

endmodule

// File: tb/tb_tinyrv1_mem_responder.sv
// Directed bench for tinyrv1_mem_responder.
// LATENCY=2, QDEPTH=4, WORDS=256.
module tb_tinyrv1_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_val;
  logic        req_rdy;
  logic        req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_val;
  logic        resp_rdy;
  logic        resp_type;
  logic [31:0] resp_rdata;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tinyrv1_mem_responder #(
    .WORDS   (256),
    .LATENCY (2),
    .QDEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .resp_type  (resp_type),
    .resp_rdata (resp_rdata),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    int n = 0;
    while (!resp_val && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_val"}, 32'(resp_val), 32'd1);
  endtask

  task automatic do_req(input logic typ, input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [31:0] exp, input string tag);
    int n = 0;
    resp_rdy  = 1'b1;
    req_val   = 1'b1;
    req_type  = typ;
    req_addr  = a;
    req_wdata = wd;
    while (!req_rdy && n < 20) begin
      tick();
      n++;
    end
    tick();
    req_val = 1'b0;
    wait_resp(tag);
    check({tag, "_type"}, 32'(resp_type), 32'(typ));
    check({tag, "_data"}, resp_rdata, exp);
    tick();
  endtask

  initial begin
    rst       = 1'b0;
    req_val   = 1'b0;
    req_type  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    resp_rdy  = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    #2;
    check("rst_resp_val", 32'(resp_val), 32'd0);
    check("rst_resp_type", 32'(resp_type), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_req_rdy", 32'(req_rdy), 32'd1);
    tick();
    tick();
    rst = 1'b1;

    // Write then read, exact latency.
    resp_rdy  = 1'b1;
    req_val   = 1'b1;
    req_type  = 1'b1;
    req_addr  = 32'h100;
    req_wdata = 32'hDEADBEEF;
    check("wr_rdy", 32'(req_rdy), 32'd1);
    tick();
    req_type = 1'b0;
    check("c1_val", 32'(resp_val), 32'd0);
    tick();
    req_val = 1'b0;
    check("c2_val", 32'(resp_val), 32'd1);
    check("c2_type", 32'(resp_type), 32'd1);
    check("c2_rdata", resp_rdata, 32'd0);
    tick();
    check("c3_val", 32'(resp_val), 32'd1);
    check("c3_type", 32'(resp_type), 32'd0);
    check("c3_rdata", resp_rdata, 32'hDEADBEEF);
    tick();
    check("c4_val", 32'(resp_val), 32'd0);

    // Reset with reads in flight.
    for (int i = 0; i < 5; i++) load(32'h40 + 32'(i * 4), 32'(i + 1));
    resp_rdy = 1'b0;
    req_val  = 1'b1;
    req_type = 1'b0;
    req_addr = 32'h40;
    tick();
    req_addr = 32'h44;
    tick();
    req_val = 1'b0;
    check("inflight_val", 32'(resp_val), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_resp_val", 32'(resp_val), 32'd0);
    check("ar_req_rdy", 32'(req_rdy), 32'd1);
    check("ar_rdata", resp_rdata, 32'd0);
    tick();
    rst      = 1'b1;
    resp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_stale", 32'(resp_val), 32'd0);
    end

    // Backpressure, then full with simultaneous deliver.
    resp_rdy = 1'b0;
    req_val  = 1'b1;
    req_type = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'h40 + 32'(i * 4);
      check("bp_rdy", 32'(req_rdy), 32'd1);
      tick();
    end
    req_addr = 32'h50;
    check("bp_full", 32'(req_rdy), 32'd0);
    tick();
    tick();
    check("bp_full2", 32'(req_rdy), 32'd0);
    check("bp_head", resp_rdata, 32'd1);
    resp_rdy = 1'b1;
    check("sim_rdy", 32'(req_rdy), 32'd0);
    tick();
    resp_rdy = 1'b0;
    check("sim_next_rdy", 32'(req_rdy), 32'd1);
    check("sim_head2", resp_rdata, 32'd2);
    tick();
    req_val = 1'b0;
    check("sim_refull", 32'(req_rdy), 32'd0);
    resp_rdy = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check("drain_val", 32'(resp_val), 32'd1);
      check("drain_data", resp_rdata, 32'(i));
      tick();
    end
    check("drain_end", 32'(resp_val), 32'd0);

    // Address wrap.
    load(32'h0, 32'h1234);
    do_req(1'b0, 32'h400, 32'h0, 32'h1234, "wrap400");
    do_req(1'b0, 32'h003, 32'h0, 32'h1234, "wrap003");

    // Backdoor collision.
    ld_en     = 1'b1;
    ld_addr   = 32'h20;
    ld_data   = 32'hAAAA;
    resp_rdy  = 1'b1;
    req_val   = 1'b1;
    req_type  = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hBBBB;
    check("col_rdy", 32'(req_rdy), 32'd1);
    tick();
    ld_en   = 1'b0;
    req_val = 1'b0;
    wait_resp("col_wr");
    check("col_wr_data", resp_rdata, 32'd0);
    tick();
    do_req(1'b0, 32'h20, 32'h0, 32'hAAAA, "col_rd");

    // Read in the same cycle as a backdoor load sees old data.
    ld_en    = 1'b1;
    ld_addr  = 32'h20;
    ld_data  = 32'h5555;
    req_val  = 1'b1;
    req_type = 1'b0;
    req_addr = 32'h20;
    tick();
    ld_en   = 1'b0;
    req_val = 1'b0;
    wait_resp("ldrd_old");
    check("ldrd_old_data", resp_rdata, 32'hAAAA);
    tick();
    do_req(1'b0, 32'h20, 32'h0, 32'h5555, "ldrd_new");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
